// File: rtl/dac_16bit_seq.sv
// dac_16bit_seq: clocked 16-bit bipolar DAC model (+/-10 V) with a valid/ready input, settle delay and toggle-charge accounting.
// Optional slew-limited output stepping is enabled with `define DAC_SLEW_LIMIT_EN.
module dac_16bit_seq #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int CHARGE_PER_BIT = 3,
    parameter int CHARGE_LIMIT   = 1000000,
    parameter int MAX_STEP       = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] code_out,
    output logic [63:0] analog_out,
    output logic        busy,
    output logic        done,
    output logic [19:0] charge,
    output logic        charge_ovr,
    input  logic        charge_clr
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [15:0]     target, code_nx;
    logic            accept, upd, fin;
    logic [20:0]     inc, sum;
    logic [19:0]     charge_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (accept ? SETTLE : IDLE) : (fin ? IDLE : SETTLE);

    always_comb begin
        din_ready = (state == IDLE);
        busy      = (state == SETTLE);
        accept    = din_valid & din_ready;
    end

`ifdef DAC_SLEW_LIMIT_EN
    logic signed [16:0] diff;
    logic [15:0]        step;
    // Signed 17-bit difference so full-scale swings compare correctly.
    assign diff = $signed({target[15], target}) - $signed({code_out[15], code_out});
    always_comb begin
        step    = int'(diff) > MAX_STEP ? code_out + 16'(MAX_STEP) :
                  int'(diff) < -MAX_STEP ? code_out - 16'(MAX_STEP) : target;
        upd     = busy;
        code_nx = upd ? step : code_out;
        fin     = upd && cnt == '0 && code_nx == target;
    end
`else
    always_comb begin
        upd     = busy && cnt == '0;
        code_nx = upd ? target : code_out;
        fin     = upd;
    end
`endif

    // Charge sums at 21 bits so the 20-bit result saturates instead of wrapping.
    always_comb begin
        inc       = 21'($countones(code_out ^ code_nx)) * 21'(CHARGE_PER_BIT);
        sum       = (charge_clr ? 21'd0 : {1'b0, charge}) + inc;
        charge_nx = sum[20] ? 20'hFFFFF : sum[19:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            target     <= '0;
            code_out   <= '0;
            analog_out <= 64'h0;
            done       <= 1'b0;
            charge     <= '0;
            charge_ovr <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                target <= din;
                cnt    <= CW'(SETTLE_CYCLES - 1);
            end else if (busy && cnt != '0)
                cnt <= cnt - 1'b1;
            if (upd) begin
                code_out   <= code_nx;
                analog_out <= $realtobits($itor($signed(code_nx)) * 10.0 / 32768.0);
            end
            if (upd || charge_clr) begin
                charge     <= charge_nx;
                charge_ovr <= (charge_ovr & ~charge_clr) | (int'(charge_nx) > CHARGE_LIMIT);
            end
        end
endmodule

// File: tb/tb_dac_16bit_seq.sv
// tb_dac_16bit_seq: directed, table-driven bench for dac_16bit_seq (CHARGE_LIMIT=50).
// The slew-limited sequence is exercised only when DAC_SLEW_LIMIT_EN is defined.
module tb_dac_16bit_seq;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] code_out;
    logic [63:0] analog_out;
    logic        busy, done;
    logic [19:0] charge;
    logic        charge_ovr;
    logic        charge_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;

    dac_16bit_seq #(.SETTLE_CYCLES(SC), .CHARGE_LIMIT(50)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .code_out(code_out), .analog_out(analog_out), .busy(busy), .done(done),
        .charge(charge), .charge_ovr(charge_ovr), .charge_clr(charge_clr)
    );

`ifdef DAC_SLEW_LIMIT_EN
    logic [15:0] din2 = '0;
    logic        v2 = 1'b0;
    logic        rdy2, busy2, done2, ovr2;
    logic [15:0] code2;
    logic [63:0] ana2;
    logic [19:0] chg2;
    dac_16bit_seq #(.SETTLE_CYCLES(1), .MAX_STEP(1024)) u_slew (
        .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(v2), .din_ready(rdy2),
        .code_out(code2), .analog_out(ana2), .busy(busy2), .done(done2),
        .charge(chg2), .charge_ovr(ovr2), .charge_clr(1'b0)
    );
`endif

    always #5 clk = ~clk;

    always @(posedge clk) if (din_valid && din_ready) acc_cnt <= acc_cnt + 1;

    typedef struct {
        logic [15:0] din;
        logic [15:0] code;
        logic [63:0] ana;
        logic [19:0] chg;
        logic        ovr;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 20);
    endtask

    task automatic send(input logic [15:0] d, output int n);
        int w = 0;
        while (!din_ready && w < 20) begin
            step();
            w++;
        end
        din = d;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        wait_done(n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int n, base, dcnt;
        vecs[0] = '{16'h8000, 16'h8000, $realtobits(-10.0), 20'd9, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h7FFF, $realtobits(32767.0 * 10.0 / 32768.0), 20'd57, 1'b1};
        vecs[2] = '{16'h0001, 16'h0001, $realtobits(10.0 / 32768.0), 20'd99, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, $realtobits(-10.0 / 32768.0), 20'd144, 1'b1};

        step();
        step();
        chk("rst_analog", analog_out, 64'h0);
        chk("rst_code", 64'(code_out), 64'h0);
        chk("rst_ready", 64'(din_ready), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_charge", 64'(charge), 64'h0);
        chk("rst_ovr", 64'(charge_ovr), 64'h0);
        rst_n = 1'b1;
        step();

        din = 16'h4000;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("settle_busy", 64'(busy), 64'h1);
        chk("settle_ready", 64'(din_ready), 64'h0);
        for (int k = 1; k < SC; k++) begin
            step();
            chk($sformatf("settle_hold_e%0d", k), analog_out, 64'h0);
            chk($sformatf("settle_nodone_e%0d", k), 64'(done), 64'h0);
        end
        step();
        chk("settle_code", 64'(code_out), 64'h4000);
        chk("settle_analog", analog_out, $realtobits(5.0));
        chk("settle_done", 64'(done), 64'h1);
        chk("settle_charge", 64'(charge), 64'd3);
        step();
        chk("done_pulse_end", 64'(done), 64'h0);
        chk("ready_back", 64'(din_ready), 64'h1);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].din, n);
            chk($sformatf("vec%0d_latency", i), 64'(n), 64'(SC));
            chk($sformatf("vec%0d_code", i), 64'(code_out), 64'(vecs[i].code));
            chk($sformatf("vec%0d_analog", i), analog_out, vecs[i].ana);
            chk($sformatf("vec%0d_charge", i), 64'(charge), 64'(vecs[i].chg));
            chk($sformatf("vec%0d_ovr", i), 64'(charge_ovr), 64'(vecs[i].ovr));
        end

        do_reset();
        base = acc_cnt;
        din = 16'h0000;
        din_valid = 1'b1;
        step();
        din = 16'hFFFF;
        wait_done(n);
        chk("b2b_lat1", 64'(n), 64'(SC));
        chk("b2b_ready_with_done", 64'(din_ready), 64'h1);
        chk("b2b_charge1", 64'(charge), 64'd0);
        step();
        din_valid = 1'b0;
        chk("b2b_accepts", 64'(acc_cnt - base), 64'd2);
        wait_done(n);
        chk("b2b_lat2", 64'(n), 64'(SC));
        chk("b2b_code", 64'(code_out), 64'hFFFF);
        chk("b2b_charge2", 64'(charge), 64'd48);
        chk("b2b_ovr", 64'(charge_ovr), 64'h0);
        for (int k = 0; k < 6; k++) step();
        chk("b2b_no_extra", 64'(acc_cnt - base), 64'd2);

        send(16'hFFFF, n);
        chk("same_code_done", 64'(n), 64'(SC));
        chk("same_code_charge", 64'(charge), 64'd48);
        send(16'h0000, n);
        chk("ovr_charge", 64'(charge), 64'd96);
        chk("ovr_set", 64'(charge_ovr), 64'h1);
        step();
        chk("ovr_sticky", 64'(charge_ovr), 64'h1);
        charge_clr = 1'b1;
        step();
        charge_clr = 1'b0;
        chk("clr_charge", 64'(charge), 64'd0);
        chk("clr_ovr", 64'(charge_ovr), 64'h0);

        din = 16'h1234;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_code", 64'(code_out), 64'h0);
        chk("abort_analog", analog_out, 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_ready", 64'(din_ready), 64'h1);
        step();
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        chk("abort_code_after", 64'(code_out), 64'h0);

`ifdef DAC_SLEW_LIMIT_EN
        do_reset();
        din2 = 16'h1000;
        v2 = 1'b1;
        step();
        v2 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("slew_code%0d", k), 64'(code2), 64'(16'(k * 1024)));
            chk($sformatf("slew_analog%0d", k), ana2, $realtobits(k * 1024.0 * 10.0 / 32768.0));
            chk($sformatf("slew_done%0d", k), 64'(done2), 64'(k == 4));
            chk($sformatf("slew_busy%0d", k), 64'(busy2), 64'(k != 4));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
